// File: rtl/march_c_engine.sv
// March C- engine: drives a single-port SRAM through the March C- sequence and checks reads.
// Latency: one op per cycle after the start edge; complete_marchc rises 10N+1 edges after start.
// Backpressure: none; enable_marchc is a held level, and dropping it aborts or acknowledges completion.
module march_c_engine #(
  parameter int ADDR_WIDTH = 4,
  parameter int DATA_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  enable_marchc,
  input  logic [DATA_WIDTH-1:0] mem_rdata,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  output logic                  mem_we,
  output logic                  mem_re,
  output logic                  complete_marchc,
  output logic                  fail,
  output logic [ADDR_WIDTH-1:0] fail_addr
);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

  localparam logic [ADDR_WIDTH-1:0] ADDR_MAX = '1;
  localparam logic [ADDR_WIDTH-1:0] ADDR_ONE = {{(ADDR_WIDTH-1){1'b0}}, 1'b1};

  state_t                state;
  // elem 0..5 selects the March element; phase picks read (0) or write (1) in two-op elements.
  // mem_addr doubles as the address counter for the op currently on the bus.
  logic [2:0]            elem;
  logic                  phase;

  // Compare stage: expected word and address of the read the SRAM sampled last edge.
  logic                  cmp_valid;
  logic [DATA_WIDTH-1:0] cmp_exp;
  logic [ADDR_WIDTH-1:0] cmp_addr;

  logic                  two_op;
  logic                  down;
  logic                  at_end;
  logic                  last_op;
  logic [2:0]            nxt_elem;
  logic                  nxt_phase;
  logic [ADDR_WIDTH-1:0] nxt_addr;
  logic                  nxt_we;
  logic                  nxt_bit;
  logic                  mismatch;

  // Work out the op that follows the one currently driven, and decode its type and data.
  always_comb begin
    two_op    = (elem >= 3'd1) && (elem <= 3'd4);
    down      = (elem == 3'd3) || (elem == 3'd4);
    at_end    = down ? (mem_addr == '0) : (mem_addr == ADDR_MAX);
    last_op   = (elem == 3'd5) && (mem_addr == ADDR_MAX);
    nxt_elem  = elem;
    nxt_phase = 1'b0;
    nxt_addr  = mem_addr;
    if (two_op && !phase) begin
      nxt_phase = 1'b1;
    end else if (at_end) begin
      nxt_elem = elem + 3'd1;
      nxt_addr = ((nxt_elem == 3'd3) || (nxt_elem == 3'd4)) ? ADDR_MAX : '0;
    end else begin
      nxt_addr = down ? (mem_addr - ADDR_ONE) : (mem_addr + ADDR_ONE);
    end
    nxt_we = (nxt_elem == 3'd0) || ((nxt_elem >= 3'd1) && (nxt_elem <= 3'd4) && nxt_phase);
    case (nxt_elem)
      3'd1, 3'd3: nxt_bit = nxt_phase;
      3'd2, 3'd4: nxt_bit = !nxt_phase;
      default:    nxt_bit = 1'b0;
    endcase
    mismatch = cmp_valid && (mem_rdata != cmp_exp);
  end

  // Sequencer FSM with registered SRAM strobes, compare stage and sticky result.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state           <= IDLE;
      elem            <= 3'd0;
      phase           <= 1'b0;
      mem_addr        <= '0;
      mem_wdata       <= '0;
      mem_we          <= 1'b0;
      mem_re          <= 1'b0;
      complete_marchc <= 1'b0;
      fail            <= 1'b0;
      fail_addr       <= '0;
      cmp_valid       <= 1'b0;
      cmp_exp         <= '0;
      cmp_addr        <= '0;
    end else begin
      // A compare only lands while the run is still live; an abort edge discards it.
      if ((state == RUN || state == DRAIN) && enable_marchc && mismatch) begin
        fail <= 1'b1;
        if (!fail) fail_addr <= cmp_addr;
      end
      case (state)
        IDLE: begin
          if (enable_marchc) begin
            // Start edge already launches op 0: E0 w0 at address 0.
            state     <= RUN;
            elem      <= 3'd0;
            phase     <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            mem_we    <= 1'b1;
            mem_re    <= 1'b0;
            fail      <= 1'b0;
            fail_addr <= '0;
            cmp_valid <= 1'b0;
          end
        end
        RUN: begin
          if (!enable_marchc) begin
            state     <= IDLE;
            mem_we    <= 1'b0;
            mem_re    <= 1'b0;
            cmp_valid <= 1'b0;
          end else begin
            // For reads mem_wdata carries the expected pattern; the SRAM ignores it.
            cmp_valid <= mem_re;
            cmp_exp   <= mem_wdata;
            cmp_addr  <= mem_addr;
            if (last_op) begin
              state  <= DRAIN;
              mem_we <= 1'b0;
              mem_re <= 1'b0;
            end else begin
              elem      <= nxt_elem;
              phase     <= nxt_phase;
              mem_addr  <= nxt_addr;
              mem_wdata <= {DATA_WIDTH{nxt_bit}};
              mem_we    <= nxt_we;
              mem_re    <= !nxt_we;
            end
          end
        end
        DRAIN: begin
          cmp_valid <= 1'b0;
          if (!enable_marchc) begin
            state <= IDLE;
          end else begin
            state           <= DONE;
            complete_marchc <= 1'b1;
          end
        end
        DONE: begin
          if (!enable_marchc) begin
            state           <= IDLE;
            complete_marchc <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
